lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- load/store unit controller for a single-port word memory.
//
// Turns byte/halfword/word CPU loads and stores into accesses on a
// word-wide data memory. Sub-word stores use a read-modify-write pass
// (ACCESS reads the word, MERGE writes it back with one lane replaced).
// Loads extract the addressed lane and sign- or zero-extend it.
//
// Optional feature: define LSU_ALIGN_CHECK_EN to enable alignment/size
// checking. When it is undefined, err is tied low, misaligned halfword
// and word addresses are truncated, and size=11 behaves as a word.
//
// Parameters
//   S  data word width in bits (>= 16)
//   L  memory depth in words; AW = $clog2(L)
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req, we, size, sign   request strobe, store/load, access size, sign-extend
//   addr, wdata           byte address, right-justified store data
//   rdata                 registered load result (held until next load)
//   done, busy, err       completion pulse, non-idle flag, error (with done)
//   mem_a, mem_din        memory word address and write data
//   mem_dout              memory read data (combinational from mem_a)
//   mem_mread, mem_mwrite memory read strobe and write enable

module lsu_ctrl #(
    parameter  int S  = 32,
    parameter  int L  = 256,
    localparam int AW = $clog2(L)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic          we,
    input  logic [1:0]    size,
    input  logic          sign,
    input  logic [31:0]   addr,
    input  logic [S-1:0]  wdata,
    output logic [S-1:0]  rdata,
    output logic          done,
    output logic          busy,
    output logic          err,
    output logic [AW-1:0] mem_a,
    output logic [S-1:0]  mem_din,
    input  logic [S-1:0]  mem_dout,
    output logic          mem_mread,
    output logic          mem_mwrite
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        MERGE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t r_state, w_next;

    // Captured request. Only the address bits that select a byte within
    // the memory are kept, so word addresses wrap modulo L.
    logic          r_we;
    logic [1:0]    r_size;
    logic          r_sign;
    logic [AW+1:0] r_addr;
    logic [S-1:0]  r_wdata;
    logic [S-1:0]  r_rmw;
    logic [S-1:0]  r_rdata;

    logic          w_is_word;
    logic          w_err;
    logic [4:0]    w_lane_sh;
    logic [S-1:0]  w_shifted;
    logic [S-1:0]  w_ld_ext;
    logic [S-1:0]  w_mask;
    logic [S-1:0]  w_ins;
    logic [S-1:0]  w_merged;

    // size=11 is treated as a word when checking is off; when checking is
    // on it is flagged as an error before the word path is ever used.
    assign w_is_word = r_size[1];

`ifdef LSU_ALIGN_CHECK_EN
    logic r_err;
    assign w_err = (r_size == 2'b11)
                 | ((r_size == 2'b01) & r_addr[0])
                 | ((r_size == 2'b10) & (|r_addr[1:0]));
    assign err   = r_err & (r_state == DONE);
`else
    assign w_err = 1'b0;
    assign err   = 1'b0;
`endif

    // Bit offset of the addressed lane: bytes use addr[1:0], halves addr[1].
    assign w_lane_sh = (r_size == 2'b00) ? {r_addr[1:0], 3'b000}
                                         : {r_addr[1], 4'b0000};
    assign w_shifted = mem_dout >> w_lane_sh;

    always_comb begin
        w_ld_ext = mem_dout;
        if (r_size == 2'b00)
            w_ld_ext = {{(S-8){r_sign & w_shifted[7]}}, w_shifted[7:0]};
        else if (r_size == 2'b01)
            w_ld_ext = {{(S-16){r_sign & w_shifted[15]}}, w_shifted[15:0]};
    end

    assign w_mask   = ((r_size == 2'b00) ? S'(8'hFF) : S'(16'hFFFF)) << w_lane_sh;
    assign w_ins    = ((r_size == 2'b00) ? S'(r_wdata[7:0]) : S'(r_wdata[15:0])) << w_lane_sh;
    assign w_merged = (r_rmw & ~w_mask) | (w_ins & w_mask);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state and memory strobes
    always_comb begin
        w_next     = r_state;
        mem_mread  = 1'b0;
        mem_mwrite = 1'b0;
        mem_din    = '0;
        case (r_state)
            IDLE: begin
                if (req) w_next = ACCESS;
            end
            ACCESS: begin
                if (w_err) begin
                    w_next = DONE;
                end else if (!r_we) begin
                    mem_mread = 1'b1;
                    w_next    = DONE;
                end else if (w_is_word) begin
                    mem_mwrite = 1'b1;
                    mem_din    = r_wdata;
                    w_next     = DONE;
                end else begin
                    mem_mread = 1'b1;
                    w_next    = MERGE;
                end
            end
            MERGE: begin
                mem_mwrite = 1'b1;
                mem_din    = w_merged;
                w_next     = DONE;
            end
            DONE: begin
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Request capture and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_sign  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rmw   <= '0;
            r_rdata <= '0;
`ifdef LSU_ALIGN_CHECK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            if (r_state == IDLE && req) begin
                r_we    <= we;
                r_size  <= size;
                r_sign  <= sign;
                r_addr  <= addr[AW+1:0];
                r_wdata <= wdata;
`ifdef LSU_ALIGN_CHECK_EN
                r_err   <= 1'b0;
`endif
            end
            if (r_state == ACCESS) begin
`ifdef LSU_ALIGN_CHECK_EN
                r_err <= w_err;
`endif
                if (!r_we)
                    r_rdata <= w_err ? '0 : w_ld_ext;
                else if (!w_is_word)
                    r_rmw <= mem_dout;
            end
        end
    end

    assign rdata = r_rdata;
    assign done  = (r_state == DONE);
    assign busy  = (r_state != IDLE);
    assign mem_a = r_addr[AW+1:2];

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
    localparam int S  = 32;
    localparam int L  = 256;
    localparam int AW = $clog2(L);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [1:0]    size = 2'b00;
    logic          sign = 1'b0;
    logic [31:0]   addr = '0;
    logic [S-1:0]  wdata = '0;
    logic [S-1:0]  rdata;
    logic          done, busy, err;
    logic [AW-1:0] mem_a;
    logic [S-1:0]  mem_din, mem_dout;
    logic          mem_mread, mem_mwrite;

    int tests = 0;
    int fails = 0;

    // Memory model; preset port lets the bench load words without racing the DUT.
    logic [S-1:0]  mem [L];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_a  = '0;
    logic [S-1:0]  pre_d  = '0;

    assign mem_dout = mem[mem_a];
    always @(posedge clk) begin
        if (mem_mwrite)  mem[mem_a] <= mem_din;
        else if (pre_we) mem[pre_a] <= pre_d;
    end

    always #5 clk = ~clk;

    lsu_ctrl #(.S(S), .L(L)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sign(sign),
        .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .busy(busy),
        .err(err), .mem_a(mem_a), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_mread(mem_mread), .mem_mwrite(mem_mwrite)
    );

    // Observations of the last transaction
    int            t_cyc, t_mrd, t_mwr;
    logic          t_err;
    logic [AW-1:0] t_a;

    task automatic preset(input logic [AW-1:0] a, input logic [S-1:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_a = a; pre_d = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Issue one request; counts negedges until done, strobe cycles seen
    // along the way, and the memory address presented in the first cycle.
    task automatic access(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [S-1:0] d);
        @(negedge clk);
        req = 1'b1; we = w; size = sz; sign = sg; addr = a; wdata = d;
        @(posedge clk);
        #1 req = 1'b0;
        t_cyc = -1; t_mrd = 0; t_mwr = 0; t_err = 1'b0; t_a = '0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) t_a = mem_a;
            t_mrd += int'(mem_mread);
            t_mwr += int'(mem_mwrite);
            if (done) begin
                t_cyc = n;
                t_err = err;
                break;
            end
        end
        if (t_cyc < 0) begin
            tests++; fails++;
            $display("FAIL timeout: done never seen (addr=%h)", a);
        end
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if ({rdata, done, busy, err, mem_a, mem_din, mem_mread, mem_mwrite} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got rdata=%h done=%b busy=%b err=%b a=%h din=%h rd=%b wr=%b want all 0",
                     rdata, done, busy, err, mem_a, mem_din, mem_mread, mem_mwrite);
        end
        @(negedge clk);
        rst_n = 1'b1;
        preset(AW'(3), 32'h8899AABB);
    endtask

    task automatic test_load_word();
        access(1'b0, 2'b10, 1'b0, 32'h0C, '0);
        tests++; if (rdata !== 32'h8899AABB) begin fails++; $display("FAIL ldw_rdata: got %h want 8899aabb", rdata); end
        tests++; if (t_cyc !== 2) begin fails++; $display("FAIL ldw_latency: got %0d want 2", t_cyc); end
        tests++; if (t_mwr !== 0 || t_mrd !== 1) begin fails++; $display("FAIL ldw_strobes: got rd=%0d wr=%0d want 1/0", t_mrd, t_mwr); end
        tests++; if (t_err !== 1'b0) begin fails++; $display("FAIL ldw_err: got %b want 0", t_err); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ldw_busy_in_done: got %b want 1", busy); end
    endtask

    task automatic test_load_sub();
        access(1'b0, 2'b00, 1'b1, 32'h0D, '0);
        tests++; if (rdata !== 32'hFFFFFFAA) begin fails++; $display("FAIL ldb_sext: got %h want ffffffaa", rdata); end
        access(1'b0, 2'b00, 1'b0, 32'h0D, '0);
        tests++; if (rdata !== 32'h000000AA) begin fails++; $display("FAIL ldb_zext: got %h want 000000aa", rdata); end
        access(1'b0, 2'b01, 1'b1, 32'h0E, '0);
        tests++; if (rdata !== 32'hFFFF8899) begin fails++; $display("FAIL ldh_sext: got %h want ffff8899", rdata); end
        access(1'b0, 2'b01, 1'b0, 32'h0C, '0);
        tests++; if (rdata !== 32'h0000AABB) begin fails++; $display("FAIL ldh_zext: got %h want 0000aabb", rdata); end
        access(1'b0, 2'b00, 1'b1, 32'h0F, '0);
        tests++; if (rdata !== 32'hFFFFFF88) begin fails++; $display("FAIL ldb_lane3: got %h want ffffff88", rdata); end
    endtask

    task automatic test_store_byte();
        access(1'b1, 2'b00, 1'b0, 32'h0E, 32'h12345677);
        @(negedge clk);
        tests++; if (mem[3] !== 32'h8877AABB) begin fails++; $display("FAIL stb_mem: got %h want 8877aabb", mem[3]); end
        tests++; if (t_mwr !== 1) begin fails++; $display("FAIL stb_mwrite_count: got %0d want 1", t_mwr); end
        tests++; if (t_cyc !== 3) begin fails++; $display("FAIL stb_latency: got %0d want 3", t_cyc); end
        tests++; if (rdata !== 32'hFFFFFF88) begin fails++; $display("FAIL stb_rdata_held: got %h want ffffff88", rdata); end
    endtask

    task automatic test_store_half_busy();
        int n_done;
        preset(AW'(3), 32'h8899AABB);
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b01; sign = 1'b0; addr = 32'h0E; wdata = 32'h0000CAFE;
        @(posedge clk);
        // Second request while busy: a word store that must be dropped.
        #1 we = 1'b1; size = 2'b10; addr = 32'h0C; wdata = 32'hDEADBEEF;
        n_done = -1;
        t_mwr = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            t_mwr += int'(mem_mwrite);
            if (done) begin n_done = n; req = 1'b0; break; end
        end
        req = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (n_done !== 3) begin fails++; $display("FAIL sth_latency: got %0d want 3", n_done); end
        tests++; if (mem[3] !== 32'hCAFEAABB) begin fails++; $display("FAIL sth_mem: got %h want cafeaabb", mem[3]); end
        tests++; if (t_mwr !== 1 || busy !== 1'b0) begin fails++; $display("FAIL sth_busy_ignore: got wr=%0d busy=%b want 1/0", t_mwr, busy); end
    endtask

    task automatic test_store_word_wrap();
        access(1'b1, 2'b10, 1'b0, 32'h0000_040C, 32'h01020304);
        @(negedge clk);
        tests++; if (t_a !== AW'(3)) begin fails++; $display("FAIL wrap_mem_a: got %h want 03", t_a); end
        tests++; if (mem[3] !== 32'h01020304) begin fails++; $display("FAIL stw_mem: got %h want 01020304", mem[3]); end
        tests++; if (t_cyc !== 2 || t_mrd !== 0 || t_mwr !== 1) begin fails++; $display("FAIL stw_timing: got cyc=%0d rd=%0d wr=%0d want 2/0/1", t_cyc, t_mrd, t_mwr); end
    endtask

    task automatic test_misaligned();
        preset(AW'(3), 32'h8899AABB);
        access(1'b0, 2'b10, 1'b0, 32'h0E, '0);
`ifdef LSU_ALIGN_CHECK_EN
        tests++; if (t_err !== 1'b1 || rdata !== '0) begin fails++; $display("FAIL misal_ldw: got err=%b rdata=%h want 1/0", t_err, rdata); end
        tests++; if (t_mrd !== 0 || t_mwr !== 0) begin fails++; $display("FAIL misal_strobes: got rd=%0d wr=%0d want 0/0", t_mrd, t_mwr); end
        access(1'b0, 2'b11, 1'b0, 32'h0C, '0);
        tests++; if (t_err !== 1'b1 || t_cyc !== 2) begin fails++; $display("FAIL size11: got err=%b cyc=%0d want 1/2", t_err, t_cyc); end
`else
        tests++; if (t_err !== 1'b0 || rdata !== 32'h8899AABB) begin fails++; $display("FAIL misal_ldw: got err=%b rdata=%h want 0/8899aabb", t_err, rdata); end
        tests++; if (t_mrd !== 1 || t_mwr !== 0) begin fails++; $display("FAIL misal_strobes: got rd=%0d wr=%0d want 1/0", t_mrd, t_mwr); end
        access(1'b0, 2'b11, 1'b0, 32'h0D, '0);
        tests++; if (t_err !== 1'b0 || rdata !== 32'h8899AABB) begin fails++; $display("FAIL size11: got err=%b rdata=%h want 0/8899aabb", t_err, rdata); end
`endif
    endtask

    task automatic test_reset_in_merge();
        preset(AW'(3), 32'h8899AABB);
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b00; sign = 1'b0; addr = 32'h0C; wdata = 32'h55;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);           // ACCESS
        @(negedge clk);           // MERGE
        tests++; if (mem_mwrite !== 1'b1) begin fails++; $display("FAIL rstm_in_merge: got mwrite=%b want 1", mem_mwrite); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (mem_mwrite !== 1'b0 || busy !== 1'b0 || mem_din !== '0 || mem_a !== '0) begin
            fails++; $display("FAIL rstm_async: got wr=%b busy=%b din=%h a=%h want 0", mem_mwrite, busy, mem_din, mem_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (mem[3] !== 32'h8899AABB || rdata !== '0) begin fails++; $display("FAIL rstm_mem: got mem=%h rdata=%h want 8899aabb/0", mem[3], rdata); end
    endtask

    initial begin
        for (int i = 0; i < L; i++) mem[i] = '0;
        test_reset();
        test_load_word();
        test_load_sub();
        test_store_byte();
        test_store_half_busy();
        test_store_word_wrap();
        test_misaligned();
        test_reset_in_merge();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
